// File: rtl/imem_load_exec_ctrl.sv
// Purpose: owns the instruction memory for the debug unit. It packs UART bytes into
//          little-endian words, writes them in order, then runs the pipeline continuously
//          or one step at a time until HALT retires.
// Latency: the write strobe comes one cycle after the 4th byte. o_load_done comes one
//          cycle after the final write. o_pipeline_enable is registered and rises one
//          cycle after the command that causes it.
// Backpressure: none. At most one byte per cycle may arrive. Bytes outside LOAD, and
//               bytes after the memory is full, are dropped.
// Ports:
//   i_clock, i_reset        : clock, synchronous active-high reset
//   i_cmd_load/run/step     : one-cycle command pulses from the debug unit
//   i_rx_data, i_rx_valid   : received UART byte and its strobe
//   i_pipeline_halted       : HALT has reached writeback
//   o_imem_write_enable,
//   o_imem_address,
//   o_imem_data             : instruction memory write port (byte address)
//   o_pipeline_enable       : fetch/pipeline clock enable
//   o_load_done, o_overflow : end-of-load pulse, sticky "memory filled without HALT"
//   o_program_size, o_state : words written so far, FSM state encoding
module imem_load_exec_ctrl #(
  parameter int            NB                = 32,
  parameter int            NB_BYTE           = 8,
  parameter int            N_OF_INSTRUCTIONS = 64,
  parameter int            NB_COUNT          = 7,
  parameter logic [NB-1:0] HALT_INSTR        = 32'hFFFF_FFFF
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_load,
  input  logic                i_cmd_run,
  input  logic                i_cmd_step,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_pipeline_halted,
  output logic                o_imem_write_enable,
  output logic [NB-1:0]       o_imem_address,
  output logic [NB-1:0]       o_imem_data,
  output logic                o_pipeline_enable,
  output logic                o_load_done,
  output logic                o_overflow,
  output logic [NB_COUNT-1:0] o_program_size,
  output logic [2:0]          o_state
);

  localparam int                    BYTES_PER_WORD = NB / NB_BYTE;
  localparam int                    NB_IDX         = $clog2(BYTES_PER_WORD);
  localparam logic [NB_IDX-1:0]     LAST_BYTE      = NB_IDX'(BYTES_PER_WORD - 1);
  localparam logic [NB_COUNT-1:0]   MAX_WORDS      = NB_COUNT'(N_OF_INSTRUCTIONS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READY  = 3'd2,
    ST_RUN    = 3'd3,
    ST_STEP   = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   enable_next;
  logic                   load_start;
  logic                   load_finish;
  logic                   byte_accept;
  logic [NB_IDX-1:0]      byte_idx;
  // Holds the bytes received so far for the current word, except the last one.
  // The newest byte goes in at the top, so after a full word byte 0 has moved
  // down to bits [7:0].
  logic [NB-NB_BYTE-1:0]  asm_word;
  logic [NB_COUNT-1:0]    word_count;

  // Once the memory is full, no more bytes are accepted. This drops everything
  // after the overflowing word.
  assign byte_accept    = (state == ST_LOAD) && i_rx_valid && (word_count != MAX_WORDS);
  assign o_program_size = word_count;
  assign o_state        = state;

  always_comb begin
    state_next  = state;
    enable_next = 1'b0;
    load_start  = 1'b0;
    load_finish = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_cmd_load) begin
          state_next = ST_LOAD;
          load_start = 1'b1;
        end
      end
      ST_LOAD: begin
        // Loading ends in the cycle the last word is on the write port. At that
        // point word_count already includes that word.
        if (o_imem_write_enable &&
            ((o_imem_data == HALT_INSTR) || (word_count == MAX_WORDS))) begin
          state_next  = ST_READY;
          load_finish = 1'b1;
        end
      end
      ST_READY: begin
        if (i_cmd_load) begin
          state_next = ST_LOAD;
          load_start = 1'b1;
        end else if (i_cmd_run) begin
          state_next  = ST_RUN;
          enable_next = 1'b1;
        end else if (i_cmd_step) begin
          state_next  = ST_STEP;
          enable_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_pipeline_halted) begin
          state_next = ST_HALTED;
        end else begin
          enable_next = 1'b1;
        end
      end
      ST_STEP: begin
        if (i_pipeline_halted) begin
          state_next = ST_HALTED;
        end else if (i_cmd_run) begin
          state_next  = ST_RUN;
          enable_next = 1'b1;
        end else if (i_cmd_step) begin
          enable_next = 1'b1;
        end
      end
      ST_HALTED: begin
        if (i_cmd_load) begin
          state_next = ST_LOAD;
          load_start = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state             <= ST_IDLE;
      o_pipeline_enable <= 1'b0;
    end else begin
      state             <= state_next;
      o_pipeline_enable <= enable_next;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      byte_idx            <= '0;
      asm_word            <= '0;
      word_count          <= '0;
      o_imem_write_enable <= 1'b0;
      o_imem_address      <= '0;
      o_imem_data         <= '0;
      o_load_done         <= 1'b0;
      o_overflow          <= 1'b0;
    end else begin
      o_imem_write_enable <= 1'b0;
      o_load_done         <= load_finish;
      if (load_start) begin
        // A new load starts clean. Any partial word left from an earlier load is dropped.
        byte_idx   <= '0;
        asm_word   <= '0;
        word_count <= '0;
        o_overflow <= 1'b0;
      end else if (byte_accept) begin
        asm_word <= {i_rx_data, asm_word[NB-NB_BYTE-1:NB_BYTE]};
        if (byte_idx == LAST_BYTE) begin
          byte_idx            <= '0;
          o_imem_write_enable <= 1'b1;
          o_imem_address      <= NB'({word_count, 2'b00});
          o_imem_data         <= {i_rx_data, asm_word};
          word_count          <= word_count + NB_COUNT'(1);
        end else begin
          byte_idx <= byte_idx + NB_IDX'(1);
        end
      end
      if (load_finish && (o_imem_data != HALT_INSTR)) begin
        o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_exec_ctrl.sv
// Directed bench for imem_load_exec_ctrl. It uses a 4-word memory so that the
// overflow case can be reached. Inputs change 1 time unit after the rising edge.
// A monitor on the falling edge records every write, load_done pulse and enabled cycle.
module tb_imem_load_exec_ctrl;

  localparam int NB                = 32;
  localparam int NB_BYTE           = 8;
  localparam int N_OF_INSTRUCTIONS = 4;
  localparam int NB_COUNT          = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_load = 1'b0;
  logic                cmd_run = 1'b0;
  logic                cmd_step = 1'b0;
  logic [NB_BYTE-1:0]  rx_data = '0;
  logic                rx_valid = 1'b0;
  logic                pipeline_halted = 1'b0;
  logic                imem_write_enable;
  logic [NB-1:0]       imem_address;
  logic [NB-1:0]       imem_data;
  logic                pipeline_enable;
  logic                load_done;
  logic                overflow;
  logic [NB_COUNT-1:0] program_size;
  logic [2:0]          state;

  int vectors     = 0;
  int miscompares = 0;
  int en_cycles   = 0;
  int done_pulses = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] ovf_words[4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};

  always #5 clock = ~clock;

  imem_load_exec_ctrl #(
    .NB(NB), .NB_BYTE(NB_BYTE), .N_OF_INSTRUCTIONS(N_OF_INSTRUCTIONS),
    .NB_COUNT(NB_COUNT), .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .i_clock(clock), .i_reset(reset),
    .i_cmd_load(cmd_load), .i_cmd_run(cmd_run), .i_cmd_step(cmd_step),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_pipeline_halted(pipeline_halted),
    .o_imem_write_enable(imem_write_enable), .o_imem_address(imem_address),
    .o_imem_data(imem_data), .o_pipeline_enable(pipeline_enable),
    .o_load_done(load_done), .o_overflow(overflow),
    .o_program_size(program_size), .o_state(state)
  );

  always @(negedge clock) begin
    if (imem_write_enable) begin
      wr_addr_q.push_back(imem_address);
      wr_data_q.push_back(imem_data);
    end
    if (load_done) done_pulses++;
    if (pipeline_enable) en_cycles++;
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_load();
    cmd_load = 1'b1; cycle(); cmd_load = 1'b0;
  endtask

  task automatic pulse_run();
    cmd_run = 1'b1; cycle(); cmd_run = 1'b0;
  endtask

  task automatic pulse_step();
    cmd_step = 1'b1; cycle(); cmd_step = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete();
    en_cycles = 0; done_pulses = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(2); reset = 1'b0;
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
    vectors++; if (imem_write_enable !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", imem_write_enable); end
    vectors++; if (imem_address !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", imem_address); end
    vectors++; if (imem_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", imem_data); end
    vectors++; if (pipeline_enable !== 1'b0) begin miscompares++; $display("FAIL reset_enable: got %b expected 0", pipeline_enable); end
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++; if (program_size !== 3'd0) begin miscompares++; $display("FAIL reset_size: got %0d expected 0", program_size); end
  endtask

  task automatic test_idle_inputs();
    clear_log();
    send_word(32'hFFFF_FFFF);
    pulse_run(); pulse_step(); idle(2);
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL idle_state: got %0d expected 0", state); end
    vectors++; if (wr_addr_q.size() != 0) begin miscompares++; $display("FAIL idle_writes: got %0d expected 0", wr_addr_q.size()); end
    vectors++; if (en_cycles != 0) begin miscompares++; $display("FAIL idle_enable: got %0d expected 0", en_cycles); end
  endtask

  task automatic test_load();
    clear_log();
    pulse_load();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL load_enter: got %0d expected 1", state); end
    send_word(32'h2001_0013);
    vectors++; if (imem_write_enable !== 1'b1) begin miscompares++; $display("FAIL load_we0: got %b expected 1", imem_write_enable); end
    vectors++; if (imem_data !== 32'h2001_0013) begin miscompares++; $display("FAIL load_data0: got %h expected 20010013", imem_data); end
    // The HALT word streams in directly behind the first word, so its byte 0
    // arrives in the same cycle as the first write strobe.
    send_word(32'hFFFF_FFFF);
    vectors++; if (imem_address !== 32'h4) begin miscompares++; $display("FAIL load_addr1: got %h expected 4", imem_address); end
    vectors++; if (imem_data !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL load_data1: got %h expected ffffffff", imem_data); end
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL load_still: got %0d expected 1", state); end
    cycle();
    vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL load_done_pulse: got %b expected 1", load_done); end
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL load_ready: got %0d expected 2", state); end
    vectors++; if (program_size !== 3'd2) begin miscompares++; $display("FAIL load_size: got %0d expected 2", program_size); end
    cycle();
    vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL load_done_single: got %b expected 0", load_done); end
    vectors++; if (wr_addr_q.size() != 2) begin miscompares++; $display("FAIL load_nwrites: got %0d expected 2", wr_addr_q.size()); end
    else begin
      vectors++; if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h2001_0013) begin miscompares++; $display("FAIL load_log0: got %h/%h expected 0/20010013", wr_addr_q[0], wr_data_q[0]); end
    end
    vectors++; if (done_pulses != 1) begin miscompares++; $display("FAIL load_done_count: got %0d expected 1", done_pulses); end
  endtask

  task automatic test_ready_inputs();
    clear_log();
    send_word(32'h1122_3344);
    idle(2);
    vectors++; if (wr_addr_q.size() != 0) begin miscompares++; $display("FAIL ready_writes: got %0d expected 0", wr_addr_q.size()); end
    vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL ready_state: got %0d expected 2", state); end
    cmd_load = 1'b1; cmd_run = 1'b1; cycle(); cmd_load = 1'b0; cmd_run = 1'b0;
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL ready_load_prio: got %0d expected 1", state); end
    pulse_run(); pulse_step(); pulse_load();
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL load_cmd_ignored: got %0d expected 1", state); end
    vectors++; if (en_cycles != 0) begin miscompares++; $display("FAIL load_enable: got %0d expected 0", en_cycles); end
    send_word(32'hFFFF_FFFF);
    cycle();
    vectors++; if (state !== 3'd2 || program_size !== 3'd1) begin miscompares++; $display("FAIL reload_ready: got state %0d size %0d expected 2/1", state, program_size); end
  endtask

  task automatic test_run();
    clear_log();
    pulse_run();
    vectors++; if (state !== 3'd3 || pipeline_enable !== 1'b1) begin miscompares++; $display("FAIL run_enter: got state %0d en %b expected 3/1", state, pipeline_enable); end
    // Halted rises 10 cycles after RUN is entered. Enable stays high in that
    // cycle too, so it is high for 11 cycles in total.
    idle(10);
    pipeline_halted = 1'b1;
    cycle();
    vectors++; if (state !== 3'd5 || pipeline_enable !== 1'b0) begin miscompares++; $display("FAIL run_halt: got state %0d en %b expected 5/0", state, pipeline_enable); end
    idle(2);
    pipeline_halted = 1'b0;
    cycle();
    vectors++; if (en_cycles != 11) begin miscompares++; $display("FAIL run_en_cycles: got %0d expected 11", en_cycles); end
    pulse_run(); pulse_step(); idle(3);
    vectors++; if (state !== 3'd5) begin miscompares++; $display("FAIL halted_ignore: got %0d expected 5", state); end
    vectors++; if (en_cycles != 11) begin miscompares++; $display("FAIL halted_enable: got %0d expected 11", en_cycles); end
  endtask

  task automatic test_step();
    pulse_load();
    send_word(32'hFFFF_FFFF);
    cycle();
    clear_log();
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      vectors++; if (pipeline_enable !== 1'b1) begin miscompares++; $display("FAIL step_pulse%0d: got %b expected 1", i, pipeline_enable); end
      cycle();
      vectors++; if (pipeline_enable !== 1'b0) begin miscompares++; $display("FAIL step_drop%0d: got %b expected 0", i, pipeline_enable); end
      idle(3);
    end
    vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL step_state: got %0d expected 4", state); end
    cmd_step = 1'b1; pipeline_halted = 1'b1;
    cycle();
    cmd_step = 1'b0;
    vectors++; if (state !== 3'd5 || pipeline_enable !== 1'b0) begin miscompares++; $display("FAIL step_halt: got state %0d en %b expected 5/0", state, pipeline_enable); end
    cycle();
    pipeline_halted = 1'b0;
    vectors++; if (en_cycles != 3) begin miscompares++; $display("FAIL step_count: got %0d expected 3", en_cycles); end
  endtask

  task automatic test_overflow();
    pulse_load();
    clear_log();
    for (int w = 0; w < 4; w++) send_word(ovf_words[w]);
    vectors++; if (imem_write_enable !== 1'b1 || imem_address !== 32'hC) begin miscompares++; $display("FAIL ovf_last_write: got we %b addr %h expected 1/c", imem_write_enable, imem_address); end
    send_byte(8'hFF);
    vectors++; if (state !== 3'd2 || overflow !== 1'b1 || load_done !== 1'b1) begin miscompares++; $display("FAIL ovf_end: got state %0d ovf %b done %b expected 2/1/1", state, overflow, load_done); end
    vectors++; if (program_size !== 3'd4) begin miscompares++; $display("FAIL ovf_size: got %0d expected 4", program_size); end
    send_word(32'hFFFF_FFFF);
    idle(2);
    vectors++; if (wr_addr_q.size() != 4) begin miscompares++; $display("FAIL ovf_nwrites: got %0d expected 4", wr_addr_q.size()); end
    else begin
      for (int w = 0; w < 4; w++) begin
        vectors++; if (wr_addr_q[w] !== 32'(4*w) || wr_data_q[w] !== ovf_words[w]) begin miscompares++; $display("FAIL ovf_log%0d: got %h/%h expected %h/%h", w, wr_addr_q[w], wr_data_q[w], 32'(4*w), ovf_words[w]); end
      end
    end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    pulse_load();
    vectors++; if (overflow !== 1'b0 || program_size !== 3'd0) begin miscompares++; $display("FAIL ovf_clear: got ovf %b size %0d expected 0/0", overflow, program_size); end
    send_word(32'hFFFF_FFFF);
    cycle();
  endtask

  task automatic test_reset_mid_load();
    pulse_load();
    clear_log();
    send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b1; cycle(); reset = 1'b0;
    vectors++; if (state !== 3'd0 || wr_addr_q.size() != 0) begin miscompares++; $display("FAIL midreset: got state %0d writes %0d expected 0/0", state, wr_addr_q.size()); end
    pulse_load();
    send_word(32'hFFFF_FFFF);
    vectors++; if (imem_write_enable !== 1'b1 || imem_address !== 32'h0 || imem_data !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL midreset_write: got we %b addr %h data %h expected 1/0/ffffffff", imem_write_enable, imem_address, imem_data); end
    cycle();
    vectors++; if (state !== 3'd2 || program_size !== 3'd1) begin miscompares++; $display("FAIL midreset_ready: got state %0d size %0d expected 2/1", state, program_size); end
    vectors++; if (wr_addr_q.size() != 1) begin miscompares++; $display("FAIL midreset_nwrites: got %0d expected 1", wr_addr_q.size()); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_inputs();
    test_load();
    test_ready_inputs();
    test_run();
    test_step();
    test_overflow();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
